// File: rtl/cache_controller_pkg.sv
// cache_controller_pkg: shared geometry and state encoding for the data-cache sequencer
package cache_controller_pkg;
  localparam int ADDR_BASE = 1024;
  localparam int CADDR_W   = 17;
  localparam int LINE_W    = 64;
  typedef enum logic [1:0] {IDLE, RD_MISS, FILL, WR_WAIT} state_t;
endpackage

// File: rtl/cache_controller_if.sv
// cache_controller_if: MEM-stage, cache and SRAM signals seen by the cache sequencer
interface cache_controller_if;
  import cache_controller_pkg::*;
  logic [31:0]        address;
  logic [31:0]        wdata;
  logic               mem_r_en;
  logic               mem_w_en;
  logic [31:0]        rdata;
  logic               ready;
  logic [CADDR_W-1:0] cache_address;
  logic [LINE_W-1:0]  cache_write_data;
  logic               cache_read_en;
  logic               cache_write_en;
  logic               cache_invoke_en;
  logic [31:0]        cache_read_data;
  logic               cache_hit;
  logic [CADDR_W-1:0] sram_address;
  logic [31:0]        sram_wdata;
  logic               sram_read_en;
  logic               sram_write_en;
  logic [LINE_W-1:0]  sram_rdata;
  logic               sram_ready;
  modport slave (
    input  address, wdata, mem_r_en, mem_w_en, cache_read_data, cache_hit, sram_rdata, sram_ready,
    output rdata, ready, cache_address, cache_write_data, cache_read_en, cache_write_en,
           cache_invoke_en, sram_address, sram_wdata, sram_read_en, sram_write_en
  );
  modport master (
    output address, wdata, mem_r_en, mem_w_en, cache_read_data, cache_hit, sram_rdata, sram_ready,
    input  rdata, ready, cache_address, cache_write_data, cache_read_en, cache_write_en,
           cache_invoke_en, sram_address, sram_wdata, sram_read_en, sram_write_en
  );
endinterface

// File: rtl/cache_controller.sv
// cache_controller: hit-or-miss sequencer between the MEM stage, a 2-way cache and a 64-bit SRAM
module cache_controller
  import cache_controller_pkg::*;
(
  input logic              clk,
  input logic              rst,
  cache_controller_if.slave bus
);
  state_t             r_state;
  logic [LINE_W-1:0]  r_line;
  logic [CADDR_W-1:0] w_caddr;
  logic               w_idle;
  logic               w_rd_hit;
  logic               w_rd_miss;
  assign w_caddr   = CADDR_W'((bus.address - 32'(ADDR_BASE)) >> 2);
  assign w_idle    = r_state == IDLE;
  // a store wins over a simultaneous load
  assign w_rd_hit  = w_idle & bus.mem_r_en & ~bus.mem_w_en & bus.cache_hit;
  assign w_rd_miss = w_idle & bus.mem_r_en & ~bus.mem_w_en & ~bus.cache_hit;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_line  <= '0;
    end else begin
      case (r_state)
        IDLE:    r_state <= bus.mem_w_en ? WR_WAIT : w_rd_miss ? RD_MISS : IDLE;
        RD_MISS: if (bus.sram_ready) begin
          r_line  <= bus.sram_rdata;
          r_state <= FILL;
        end
        FILL:    r_state <= IDLE;
        default: if (bus.sram_ready) r_state <= IDLE;
      endcase
    end
  end
  assign bus.cache_address    = w_caddr;
  assign bus.sram_address     = w_caddr;
  assign bus.cache_write_data = r_line;
  assign bus.sram_wdata       = bus.wdata;
  assign bus.cache_read_en    = w_rd_hit;
  assign bus.cache_write_en   = r_state == FILL;
  assign bus.cache_invoke_en  = w_idle & bus.mem_w_en & bus.cache_hit;
  assign bus.sram_read_en     = r_state == RD_MISS;
  assign bus.sram_write_en    = r_state == WR_WAIT;
  assign bus.ready = (w_idle & ~bus.mem_w_en & ~w_rd_miss) | (r_state == FILL)
                   | ((r_state == WR_WAIT) & bus.sram_ready);
  assign bus.rdata = (r_state == FILL) ? (w_caddr[0] ? r_line[63:32] : r_line[31:0])
                   : w_rd_hit ? bus.cache_read_data : 32'd0;
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed and randomised-latency checks of the cache sequencer
module tb_cache_controller;
  import cache_controller_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  cache_controller_if bus();
  cache_controller dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  // behavioural 2-way cache with one-bit victim pointer per set
  bit         c_valid [2][64];
  bit [9:0]   c_tag   [2][64];
  bit [63:0]  c_data  [2][64];
  bit         c_lru   [64];
  logic [5:0] c_idx;
  logic [9:0] c_tg;
  logic       h0, h1;
  logic [63:0] c_line;
  assign c_idx  = bus.cache_address[6:1];
  assign c_tg   = bus.cache_address[16:7];
  assign h0     = c_valid[0][c_idx] && c_tag[0][c_idx] == c_tg;
  assign h1     = c_valid[1][c_idx] && c_tag[1][c_idx] == c_tg;
  assign c_line = h1 ? c_data[1][c_idx] : c_data[0][c_idx];
  assign bus.cache_hit       = h0 | h1;
  assign bus.cache_read_data = bus.cache_address[0] ? c_line[63:32] : c_line[31:0];
  always @(posedge clk) begin
    if (bus.cache_write_en) begin
      c_valid[c_lru[c_idx]][c_idx] <= 1'b1;
      c_tag[c_lru[c_idx]][c_idx]   <= c_tg;
      c_data[c_lru[c_idx]][c_idx]  <= bus.cache_write_data;
      c_lru[c_idx]                 <= ~c_lru[c_idx];
    end
    if (bus.cache_read_en) c_lru[c_idx] <= h0;
    if (bus.cache_invoke_en) begin
      if (h0) c_valid[0][c_idx] <= 1'b0;
      if (h1) c_valid[1][c_idx] <= 1'b0;
    end
  end
  // SRAM responder: pulses ready s_delay cycles after it first sees a request
  bit         s_written [512];
  bit  [31:0] s_wmem    [512];
  int         s_delay = 0;
  int         s_cnt = 0;
  logic       s_ready = 1'b0;
  logic [63:0] s_rdata = '0;
  logic [8:0] s_wa;
  assign s_wa = bus.sram_address[8:0];
  assign bus.sram_ready = s_ready;
  assign bus.sram_rdata = s_rdata;
  function automatic logic [31:0] init_word(int k);
    return k == 0 ? 32'hA : k == 1 ? 32'hB : (32'hC0DE_0000 | 32'(k));
  endfunction
  function automatic logic [31:0] s_word(int k);
    return s_written[k] ? s_wmem[k] : init_word(k);
  endfunction
  always @(posedge clk) begin
    s_ready <= 1'b0;
    if ((bus.sram_read_en || bus.sram_write_en) && !s_ready) begin
      if (s_cnt >= s_delay) begin
        s_ready <= 1'b1;
        s_cnt   <= 0;
        s_rdata <= {s_word(int'({s_wa[8:1], 1'b1})), s_word(int'({s_wa[8:1], 1'b0}))};
        if (bus.sram_write_en) begin
          s_written[s_wa] <= 1'b1;
          s_wmem[s_wa]    <= bus.sram_wdata;
        end
      end else s_cnt <= s_cnt + 1;
    end else s_cnt <= 0;
  end
  int n_rd = 0, n_cw = 0, n_inv = 0;
  always @(negedge clk) begin
    n_rd  += int'(bus.sram_read_en);
    n_cw  += int'(bus.cache_write_en);
    n_inv += int'(bus.cache_invoke_en);
  end
  logic [31:0] ref_mem [512];
  // drives one request after a rising edge and returns at the negedge where ready is seen
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       output int stalls, output logic [31:0] data);
    @(posedge clk);
    #1;
    bus.address = addr; bus.wdata = wd; bus.mem_r_en = rd; bus.mem_w_en = wr;
    stalls = 40;
    data = 'x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        stalls = i;
        data = bus.rdata;
        break;
      end
    end
  endtask
  task automatic test_reset();
    #1;
    vectors++;
    if (bus.ready !== 1'b1 || bus.rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b rdata=%h want ready=1 rdata=0", bus.ready, bus.rdata);
    end
    vectors++;
    if ({bus.cache_read_en, bus.cache_write_en, bus.cache_invoke_en, bus.sram_read_en, bus.sram_write_en} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_enables: got %b want 00000",
               {bus.cache_read_en, bus.cache_write_en, bus.cache_invoke_en, bus.sram_read_en, bus.sram_write_en});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_load_miss();
    int st;
    logic [31:0] d;
    s_delay = 3;
    issue(1'b1, 1'b0, 32'h400, 32'h0, st, d);
    vectors++;
    if (st !== 6) begin miscompares++; $display("FAIL miss_latency: got %0d want 6", st); end
    vectors++;
    if (d !== 32'hA) begin miscompares++; $display("FAIL miss_rdata: got %h want 0000000a", d); end
    vectors++;
    if (bus.cache_write_en !== 1'b1 || bus.cache_write_data !== {32'hB, 32'hA}) begin
      miscompares++;
      $display("FAIL fill_line: we=%b data=%h want we=1 data=0000000b0000000a", bus.cache_write_en, bus.cache_write_data);
    end
    vectors++;
    if (bus.sram_address !== 17'd0 || bus.cache_address !== 17'd0) begin
      miscompares++;
      $display("FAIL addr_xlate: sram=%h cache=%h want 0", bus.sram_address, bus.cache_address);
    end
  endtask
  task automatic test_load_hit();
    int st, rd0;
    logic [31:0] d;
    rd0 = n_rd;
    issue(1'b1, 1'b0, 32'h404, 32'h0, st, d);
    vectors++;
    if (st !== 0 || d !== 32'hB) begin
      miscompares++;
      $display("FAIL hit_word: stalls=%0d rdata=%h want 0 0000000b", st, d);
    end
    vectors++;
    if (bus.cache_read_en !== 1'b1 || bus.cache_address !== 17'd1) begin
      miscompares++;
      $display("FAIL hit_strobe: read_en=%b addr=%h want 1 00001", bus.cache_read_en, bus.cache_address);
    end
    vectors++;
    if (n_rd !== rd0) begin miscompares++; $display("FAIL hit_no_sram: got %0d sram reads want 0", n_rd - rd0); end
  endtask
  task automatic test_store_invalidate();
    int st, inv0;
    logic [31:0] d;
    s_delay = 2;
    inv0 = n_inv;
    issue(1'b0, 1'b1, 32'h400, 32'h55, st, d);
    vectors++;
    if (st !== 4) begin miscompares++; $display("FAIL store_latency: got %0d want 4", st); end
    vectors++;
    if (bus.sram_write_en !== 1'b1 || bus.sram_wdata !== 32'h55) begin
      miscompares++;
      $display("FAIL store_held: write_en=%b wdata=%h want 1 00000055", bus.sram_write_en, bus.sram_wdata);
    end
    vectors++;
    if (n_inv - inv0 !== 1) begin miscompares++; $display("FAIL store_invoke: got %0d cycles want 1", n_inv - inv0); end
    ref_mem[0] = 32'h55;
    issue(1'b1, 1'b0, 32'h400, 32'h0, st, d);
    vectors++;
    if (st !== 5 || d !== 32'h55) begin
      miscompares++;
      $display("FAIL reload_miss: stalls=%0d rdata=%h want 5 00000055", st, d);
    end
  endtask
  task automatic test_both_enables();
    int st, rd0;
    logic [31:0] d;
    s_delay = 1;
    rd0 = n_rd;
    issue(1'b1, 1'b1, 32'h408, 32'h77, st, d);
    vectors++;
    if (st !== 3) begin miscompares++; $display("FAIL both_latency: got %0d want 3", st); end
    vectors++;
    if (n_rd !== rd0) begin miscompares++; $display("FAIL both_no_read: got %0d sram reads want 0", n_rd - rd0); end
    ref_mem[2] = 32'h77;
    issue(1'b1, 1'b0, 32'h408, 32'h0, st, d);
    vectors++;
    if (st !== 4 || d !== 32'h77) begin
      miscompares++;
      $display("FAIL both_reload: stalls=%0d rdata=%h want 4 00000077", st, d);
    end
  endtask
  task automatic test_reset_mid();
    int st, cw0;
    logic [31:0] d;
    s_delay = 7;
    @(posedge clk);
    #1;
    bus.address = 32'h500; bus.mem_r_en = 1'b1; bus.mem_w_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.sram_read_en !== 1'b1) begin miscompares++; $display("FAIL mid_pending: sram_read_en=%b want 1", bus.sram_read_en); end
    #2;
    rst = 1'b0;
    bus.mem_r_en = 1'b0;
    cw0 = n_cw;
    #1;
    vectors++;
    if (bus.sram_read_en !== 1'b0 || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_async: sram_read_en=%b ready=%b want 0 1", bus.sram_read_en, bus.ready);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (n_cw !== cw0 || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_release: cache writes=%0d ready=%b want 0 1", n_cw - cw0, bus.ready);
    end
    s_delay = 0;
    issue(1'b1, 1'b0, 32'h500, 32'h0, st, d);
    vectors++;
    if (st !== 3 || d !== ref_mem[64]) begin
      miscompares++;
      $display("FAIL mid_retry: stalls=%0d rdata=%h want 3 %h", st, d, ref_mem[64]);
    end
  endtask
  task automatic test_random();
    int st, w;
    logic [31:0] d, wd;
    logic st_op;
    for (int n = 0; n < 100; n++) begin
      s_delay = int'($urandom_range(0, 7));
      w = int'($urandom_range(0, 3)) * 128 + int'($urandom_range(0, 3)) * 2 + int'($urandom_range(0, 1));
      st_op = $urandom_range(0, 2) == 0;
      wd = $urandom;
      issue(~st_op, st_op, 32'h400 + 32'(w * 4), wd, st, d);
      vectors++;
      if (st == 40) begin
        miscompares++;
        $display("FAIL rand_timeout: op %0d word %0d got no ready want ready within 40", n, w);
      end else if (!st_op && d !== ref_mem[w]) begin
        miscompares++;
        $display("FAIL rand_load: op %0d word %0d got %h want %h", n, w, d, ref_mem[w]);
      end
      if (st_op) ref_mem[w] = wd;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation got stuck want completion");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 512; k++) ref_mem[k] = init_word(k);
    bus.address = 32'h400; bus.wdata = '0; bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_invalidate();
    test_both_enables();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
